vc_test_multi_delay_source: RTL and testbench

- Multi-channel test source with programmable inter-message delay. It is the parametrised successor of the single-channel random-delay source.
- Each of p_num_chans independent channels streams its own message list over its own val/rdy interface.
- Per-channel delay mode: none, fixed, LFSR-random or frozen. The LFSR makes random delays deterministic and reproducible across simulators.
- Used in unit-test harnesses to drive multi-port DUTs (routers, arbiters, multi-bank memories).

---
 rtl/vc_test_delay_pkg.sv | 39 +++
 rtl/vc_test_delay_chan.sv | 130 +++++++++++++
 rtl/vc_test_multi_delay_source.sv | 47 ++++
 tb/tb_vc_test_multi_delay_source.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_test_delay_pkg.sv
// rtl/vc_test_delay_pkg.sv - shared encodings and LFSR helpers for the multi-channel delay source
package vc_test_delay_pkg;

   // Per-channel delay mode as presented on the mode bus
   typedef enum logic [1:0] {
      MODE_NONE   = 2'd0,
      MODE_FIXED  = 2'd1,
      MODE_RAND   = 2'd2,
      MODE_FREEZE = 2'd3
   } mode_e;

   // Per-channel sequencing state
   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_DELAY = 2'd1,
      ST_SEND  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Galois feedback for x^16+x^14+x^13+x^11
   localparam logic [15:0] LFSR_MASK = 16'hB400;
   // Per-channel seed spreading constant
   localparam logic [15:0] SEED_MIX  = 16'h9E37;

   // Seed for channel chan; an all-zero LFSR would lock up, so zero maps to 1
   function automatic logic [15:0] chan_seed(input logic [15:0] base, input int unsigned chan);
      logic [31:0] prod;
      logic [15:0] s;
      prod = chan * {16'd0, SEED_MIX};
      s    = base ^ prod[15:0];
      return (s == 16'd0) ? 16'h0001 : s;
   endfunction

   // One Galois shift step
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {1'b0, l[15:1]} ^ (l[0] ? LFSR_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/vc_test_delay_chan.sv
// rtl/vc_test_delay_chan.sv - one message channel with programmable inter-message delay
module vc_test_delay_chan
   import vc_test_delay_pkg::*;
#(
   parameter int          p_msg_nbits   = 8,
   parameter int          p_num_msgs    = 1024,
   parameter int          p_delay_nbits = 8,
   parameter int          p_idx_nbits   = $clog2(p_num_msgs + 1),
   parameter logic [15:0] p_seed        = 16'hACE1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [1:0]               mode,
   input  logic [p_delay_nbits-1:0] max_delay,
   input  logic [p_idx_nbits-1:0]   num_msgs,
   output logic                     val,
   input  logic                     rdy,
   output logic [p_msg_nbits-1:0]   msg,
   output logic                     done
);

   localparam int p_addr_nbits = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;

   // Message list, preloaded from outside before reset release; never reset
   logic [p_msg_nbits-1:0] m [p_num_msgs];

   state_e                   state_q, state_d;
   logic [p_idx_nbits-1:0]   idx_q,   idx_d;
   logic [p_delay_nbits-1:0] cnt_q,   cnt_d;
   logic [15:0]              lfsr_q,  lfsr_d;

   logic                     frozen;
   logic [p_delay_nbits:0]   bound;
   logic [p_delay_nbits:0]   rand_mod;
   logic [p_delay_nbits-1:0] draw_d;
   logic [p_idx_nbits-1:0]   idx_inc;
   logic [p_addr_nbits-1:0]  addr;

   assign frozen  = (mode == MODE_FREEZE);
   assign idx_inc = idx_q + p_idx_nbits'(1);
   assign addr    = idx_q[p_addr_nbits-1:0];

   // Delay that a draw would produce this cycle; bound is one bit wider so all-ones max_delay is legal
   always_comb begin
      bound    = {1'b0, max_delay} + (p_delay_nbits + 1)'(1);
      rand_mod = {1'b0, lfsr_q[p_delay_nbits-1:0]} % bound;
      draw_d   = '0;
      case (mode_e'(mode))
         MODE_NONE:   draw_d = '0;
         MODE_FIXED:  draw_d = max_delay;
         MODE_RAND:   draw_d = rand_mod[p_delay_nbits-1:0];
         MODE_FREEZE: draw_d = '0;
         default:     draw_d = '0;
      endcase
   end

   // Next-state: START/DELAY hold under freeze, SEND only advances on a handshake
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      lfsr_d  = lfsr_q;
      case (state_q)
         ST_START: begin
            if (!frozen) begin
               if (num_msgs == '0) begin
                  state_d = ST_DONE;
               end else begin
                  lfsr_d = lfsr_step(lfsr_q);
                  if (draw_d == '0) begin
                     state_d = ST_SEND;
                  end else begin
                     state_d = ST_DELAY;
                     cnt_d   = draw_d;
                  end
               end
            end
         end
         ST_DELAY: begin
            if (!frozen) begin
               if (cnt_q == p_delay_nbits'(1)) begin
                  state_d = ST_SEND;
               end else begin
                  cnt_d = cnt_q - p_delay_nbits'(1);
               end
            end
         end
         ST_SEND: begin
            if (rdy) begin
               idx_d = idx_inc;
               if (idx_inc == num_msgs) begin
                  state_d = ST_DONE;
               end else begin
                  lfsr_d = lfsr_step(lfsr_q);
                  if (draw_d != '0) begin
                     state_d = ST_DELAY;
                     cnt_d   = draw_d;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_START;
         end
      endcase
   end

   // State registers; reset aborts any transfer immediately
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_START;
         idx_q   <= '0;
         cnt_q   <= '0;
         lfsr_q  <= p_seed;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
      end
   end

   assign val  = (state_q == ST_SEND);
   assign done = (state_q == ST_DONE);
   assign msg  = (idx_q < p_idx_nbits'(p_num_msgs)) ? m[addr] : '0;

endmodule

// File: rtl/vc_test_multi_delay_source.sv
// rtl/vc_test_multi_delay_source.sv - independent delayed message sources on flattened buses
module vc_test_multi_delay_source
   import vc_test_delay_pkg::*;
#(
   parameter int          p_msg_nbits   = 8,
   parameter int          p_num_msgs    = 1024,
   parameter int          p_num_chans   = 4,
   parameter int          p_delay_nbits = 8,
   parameter logic [15:0] p_lfsr_seed   = 16'hACE1,
   parameter int          p_idx_nbits   = $clog2(p_num_msgs + 1)
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [2*p_num_chans-1:0]             mode,
   input  logic [p_delay_nbits*p_num_chans-1:0] max_delay,
   input  logic [p_idx_nbits*p_num_chans-1:0]   num_msgs,
   output logic [p_num_chans-1:0]               val,
   input  logic [p_num_chans-1:0]               rdy,
   output logic [p_msg_nbits*p_num_chans-1:0]   msg,
   output logic [p_num_chans-1:0]               done,
   output logic                                 all_done
);

   // One channel per slice of the flattened buses
   for (genvar c = 0; c < p_num_chans; c++) begin : g_chan
      vc_test_delay_chan #(
         .p_msg_nbits   (p_msg_nbits),
         .p_num_msgs    (p_num_msgs),
         .p_delay_nbits (p_delay_nbits),
         .p_idx_nbits   (p_idx_nbits),
         .p_seed        (chan_seed(p_lfsr_seed, c))
      ) u_chan (
         .clk       (clk),
         .reset_n   (reset_n),
         .mode      (mode[2*c +: 2]),
         .max_delay (max_delay[c*p_delay_nbits +: p_delay_nbits]),
         .num_msgs  (num_msgs[c*p_idx_nbits +: p_idx_nbits]),
         .val       (val[c]),
         .rdy       (rdy[c]),
         .msg       (msg[c*p_msg_nbits +: p_msg_nbits]),
         .done      (done[c])
      );
   end

   assign all_done = &done;

endmodule

// File: tb/tb_vc_test_multi_delay_source.sv
// tb/tb_vc_test_multi_delay_source.sv - directed bench with transaction-level reference model
module tb_vc_test_multi_delay_source;

   localparam int CH = 2;
   localparam int NM = 16;
   localparam int MW = 8;
   localparam int DW = 8;
   localparam int IW = 5;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic [2*CH-1:0]   mode = '0;
   logic [DW*CH-1:0]  max_delay = '0;
   logic [IW*CH-1:0]  num_msgs = '0;
   logic [CH-1:0]     val;
   logic [CH-1:0]     rdy = '1;
   logic [MW*CH-1:0]  msg;
   logic [CH-1:0]     done;
   logic              all_done;

   vc_test_multi_delay_source #(
      .p_msg_nbits   (MW),
      .p_num_msgs    (NM),
      .p_num_chans   (CH),
      .p_delay_nbits (DW),
      .p_lfsr_seed   (16'hACE1)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .mode      (mode),
      .max_delay (max_delay),
      .num_msgs  (num_msgs),
      .val       (val),
      .rdy       (rdy),
      .msg       (msg),
      .done      (done),
      .all_done  (all_done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [7:0]  mem_m [CH][NM];
   bit          started [CH];
   bit          mdone   [CH];
   int          gap     [CH];
   int          k       [CH];
   logic [15:0] ml      [CH];
   int          first_val  [CH];
   int          first_done [CH];
   logic [CH-1:0] exp_done;
   int md, mx, nm;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference seed and LFSR sequence written straight from the polynomial
   function automatic logic [15:0] ref_seed(int c);
      logic [31:0] p;
      logic [15:0] s;
      p = c * 32'h9E37;
      s = 16'hACE1 ^ p[15:0];
      return (s == 0) ? 16'h0001 : s;
   endfunction

   function automatic int draw(int c, int dmode, int dmax);
      int d;
      case (dmode)
         1:       d = dmax;
         2:       d = int'(ml[c][7:0]) % (dmax + 1);
         default: d = 0;
      endcase
      ml[c] = ml[c][0] ? ((ml[c] >> 1) ^ 16'hB400) : (ml[c] >> 1);
      return d;
   endfunction

   always @(posedge clk) if (reset_n) cyc <= cyc + 1;

   // Model: after each draw of d, val rises after exactly d non-frozen idle cycles
   always @(negedge clk) begin
      if (!reset_n) begin
         cyc = 0;
         check("rst_val", {30'd0, val}, 32'd0);
         check("rst_done", {30'd0, done}, 32'd0);
         check("rst_all_done", {31'd0, all_done}, 32'd0);
         for (int c = 0; c < CH; c++) begin
            started[c] = 0; mdone[c] = 0; gap[c] = 0; k[c] = 0;
            ml[c] = ref_seed(c); first_val[c] = -1; first_done[c] = -1;
         end
      end else begin
         for (int c = 0; c < CH; c++) exp_done[c] = mdone[c];
         check("all_done", {31'd0, all_done}, {31'd0, &exp_done});
         for (int c = 0; c < CH; c++) begin
            md = int'(mode[2*c +: 2]);
            mx = int'(max_delay[DW*c +: DW]);
            nm = int'(num_msgs[IW*c +: IW]);
            if (val[c] === 1'b1 && first_val[c] < 0) first_val[c] = cyc;
            if (done[c] === 1'b1 && first_done[c] < 0) first_done[c] = cyc;
            check($sformatf("ch%0d_done", c), {31'd0, done[c]}, {31'd0, mdone[c]});
            if (mdone[c]) begin
               check($sformatf("ch%0d_val_done", c), {31'd0, val[c]}, 32'd0);
            end else if (!started[c]) begin
               check($sformatf("ch%0d_val_start", c), {31'd0, val[c]}, 32'd0);
               if (md != 3) begin
                  started[c] = 1;
                  if (nm == 0) mdone[c] = 1;
                  else gap[c] = draw(c, md, mx);
               end
            end else if (gap[c] > 0) begin
               check($sformatf("ch%0d_val_gap", c), {31'd0, val[c]}, 32'd0);
               if (md != 3) gap[c]--;
            end else begin
               check($sformatf("ch%0d_val_send", c), {31'd0, val[c]}, 32'd1);
               check($sformatf("ch%0d_msg", c), {24'd0, msg[MW*c +: MW]}, {24'd0, mem_m[c][k[c]]});
               if (rdy[c]) begin
                  k[c]++;
                  if (k[c] == nm) mdone[c] = 1;
                  else gap[c] = draw(c, md, mx);
               end
            end
         end
      end
   end

   task automatic load(int c, int i, logic [7:0] v);
      mem_m[c][i] = v;
      if (c == 0) dut.g_chan[0].u_chan.m[i] = v;
      else        dut.g_chan[1].u_chan.m[i] = v;
   endtask

   task automatic set_ch(int c, logic [1:0] m, logic [7:0] dmax, logic [4:0] n);
      mode[2*c +: 2]       = m;
      max_delay[DW*c +: DW] = dmax;
      num_msgs[IW*c +: IW]  = n;
   endtask

   task automatic enter_reset();
      @(posedge clk);
      #2 reset_n = 1'b0;
   endtask

   task automatic leave_reset();
      @(posedge clk);
      @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   initial begin
      for (int c = 0; c < CH; c++)
         for (int i = 0; i < NM; i++) load(c, i, 8'(16*c + i + 1));
      #1 reset_n = 1'b0;

      // T1: plain stream, and an empty channel
      load(0, 0, 8'd11); load(0, 1, 8'd22); load(0, 2, 8'd33); load(0, 3, 8'd44);
      set_ch(0, 2'd0, 8'd0, 5'd4);
      set_ch(1, 2'd0, 8'd0, 5'd0);
      rdy = 2'b11;
      leave_reset();
      repeat (10) @(posedge clk);
      #2;
      check("t1_first_val", first_val[0], 1);
      check("t1_first_done", first_done[0], 5);
      check("t1_empty_done", first_done[1], 1);
      check("t1_empty_no_val", first_val[1], -1);

      // T2: fixed delay of 3
      enter_reset();
      set_ch(0, 2'd1, 8'd3, 5'd3);
      set_ch(1, 2'd0, 8'd0, 5'd2);
      leave_reset();
      repeat (20) @(posedge clk);
      #2;
      check("t2_first_val", first_val[0], 4);
      check("t2_first_done", first_done[0], 13);

      // T3: random delays, same data on both channels
      enter_reset();
      for (int i = 0; i < 6; i++) begin load(0, i, 8'(i + 100)); load(1, i, 8'(i + 100)); end
      set_ch(0, 2'd2, 8'd5, 5'd6);
      set_ch(1, 2'd2, 8'd5, 5'd6);
      leave_reset();
      repeat (45) @(posedge clk);
      #2;
      check("t3_ch0_first_val", first_val[0], 4);
      check("t3_ch1_first_val", first_val[1], 5);
      check("t3_all_done", {31'd0, all_done}, 32'd1);

      // T4: backpressure on ch0 for 5 cycles, irregular rdy on ch1
      enter_reset();
      set_ch(0, 2'd0, 8'd0, 5'd3);
      set_ch(1, 2'd2, 8'd5, 5'd5);
      rdy = 2'b00;
      leave_reset();
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #2;
         rdy[0] = (n >= 6);
         rdy[1] = (n % 3 != 0);
         if (n == 4) check("t4_held_msg", {24'd0, msg[7:0]}, {24'd0, mem_m[0][0]});
      end
      check("t4_first_done", first_done[0], 9);

      // T5: freeze mid-delay on ch0; freeze across stalled and back-to-back sends on ch1
      enter_reset();
      set_ch(0, 2'd1, 8'd4, 5'd2);
      set_ch(1, 2'd1, 8'd2, 5'd6);
      rdy = 2'b11;
      leave_reset();
      for (int n = 1; n <= 35; n++) begin
         @(posedge clk);
         #2;
         if (n == 2)  mode[1:0] = 2'd3;
         if (n == 12) mode[1:0] = 2'd1;
         mode[3:2] = (n >= 4 && n <= 9) ? 2'd3 : 2'd1;
         rdy[1]    = !(n >= 3 && n <= 5);
      end
      check("t5_first_val", first_val[0], 15);
      check("t5_first_done", first_done[0], 21);

      // T6: asynchronous reset mid-SEND, then full replay
      enter_reset();
      for (int i = 0; i < 4; i++) begin load(0, i, 8'(i + 50)); load(1, i, 8'(i + 60)); end
      set_ch(0, 2'd0, 8'd0, 5'd4);
      set_ch(1, 2'd2, 8'd5, 5'd4);
      rdy = 2'b11;
      leave_reset();
      repeat (2) @(posedge clk);
      #2;
      check("t6_val_before", {31'd0, val[0]}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("t6_val_async", {30'd0, val}, 32'd0);
      check("t6_done_async", {30'd0, done}, 32'd0);
      leave_reset();
      repeat (25) @(posedge clk);
      #2;
      check("t6_first_val0", first_val[0], 1);
      check("t6_first_val1", first_val[1], 5);
      check("t6_first_done0", first_done[0], 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
